apb_master_bridge: RTL

Registered APB initiator between the `simple_rv` data-memory port and the APB node. It converts the core's single-cycle `dmem_wen`/`dmem_ren` request into a compliant two-phase APB transfer (SETUP, then ACCESS) and honours slave `PREADY` wait states. It stalls the core until the transfer completes and returns read data and the slave error flag.

---
 rtl/apb_mst_pkg.sv | 18 +
 rtl/apb_mst_wdog.sv | 32 +++
 rtl/apb_master_bridge.sv | 104 ++++++++++
 3 files changed

// File: rtl/apb_mst_pkg.sv
// Shared types and default constants for the APB master bridge.
// The APB_MST_TIMEOUT_EN build option uses TMO_RDATA as the forced read value.
package apb_mst_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } apb_mst_state_e;

   localparam int APB_ADDR_W       = 32;
   localparam int APB_DATA_W       = 32;
   localparam int APB_TIMEOUT_DFLT = 255;

   localparam logic [APB_DATA_W-1:0] TMO_RDATA = '0;

endpackage

// File: rtl/apb_mst_wdog.sv
// ACCESS-phase wait counter; present only in builds with APB_MST_TIMEOUT_EN.
// expired is asserted during the TIMEOUT_CYCLES-th consecutive wait cycle.
module apb_mst_wdog
   import apb_mst_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DFLT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

   // The increment that reaches TIMEOUT_CYCLES coincides with the forced completion.
   assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Registered two-phase APB initiator for the simple_rv data-memory port.
// Define APB_MST_TIMEOUT_EN to bound ACCESS wait states by TIMEOUT_CYCLES.
module apb_master_bridge
   import apb_mst_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_W,
   parameter int DATA_WIDTH     = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DFLT
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic [ADDR_WIDTH-1:0] dmem_addr,
   input  logic [DATA_WIDTH-1:0] dmem_data_in,
   input  logic                  dmem_wen,
   input  logic                  dmem_ren,
   output logic [DATA_WIDTH-1:0] dmem_data_out,
   output logic                  dmem_stall,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic                  PWRITE,
   output logic                  PSEL,
   output logic                  PENABLE,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR,
   output apb_mst_state_e        state_dbg
);

   // Core handshake: the core holds wen/ren and its operands while dmem_stall is
   // high; the transfer is accepted on the edge that ends the DONE cycle (stall low).
   apb_mst_state_e state, state_nxt;
   logic           req;
   logic           expired;

   assign req        = dmem_wen | dmem_ren;
   assign dmem_stall = req & (state != DONE) & ~HRESET;
   assign state_dbg  = state;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef APB_MST_TIMEOUT_EN
   apb_mst_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk    (HCLK),
      .rst    (HRESET),
      .clr    (state == SETUP),
      .en     ((state == ACCESS) && !PREADY),
      .expired(expired)
   );
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (PREADY || expired) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // APB strobes are decoded from the next state so they leave flops directly.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state         <= IDLE;
         PSEL          <= 1'b0;
         PENABLE       <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_err       <= 1'b0;
         PADDR         <= '0;
         PWDATA        <= '0;
         PWRITE        <= 1'b0;
         dmem_data_out <= '0;
      end else begin
         state     <= state_nxt;
         PSEL      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
         PENABLE   <= (state_nxt == ACCESS);
         rsp_valid <= (state_nxt == DONE);
         if ((state == IDLE) && req) begin
            PADDR  <= dmem_addr;
            PWDATA <= dmem_data_in;
            PWRITE <= dmem_wen;
         end
         if (state == ACCESS) begin
            if (PREADY) begin
               rsp_err <= PSLVERR;
               if (!PWRITE) dmem_data_out <= PRDATA;
            end else if (expired) begin
               rsp_err       <= 1'b1;
               dmem_data_out <= DATA_WIDTH'(TMO_RDATA);
            end
         end
      end
   end

endmodule
